// File: rtl/auto_route_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : auto_route_cmd_if
// Description : Signal bundle between the navigation FSM side and the
//               autonomous command source. The navigation side (master)
//               drives mode, FSM state and detector pattern. The command
//               source (slave) returns the one-hot command levels and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface auto_route_cmd_if;
    logic       enable;
    logic [1:0] nav_state;
    logic [3:0] detector;
    logic       left;
    logic       right;
    logic       straight;
    logic       back;
    logic       busy;
    logic       timeout_err;
    logic [2:0] right_run;

    modport master (
        output enable, nav_state, detector,
        input  left, right, straight, back, busy, timeout_err, right_run
    );

    modport slave (
        input  enable, nav_state, detector,
        output left, right, straight, back, busy, timeout_err, right_run
    );
endinterface
`default_nettype wire

// File: rtl/auto_route_cmd.sv
`default_nettype none
// ============================================================================
// Module      : auto_route_cmd
// Description : Autonomous replacement for the left/right/straight/back
//               buttons. At a crossroad it debounces the detector pattern,
//               chooses a direction with a right-hand wall-follow policy
//               (with a loop guard on repeated rights), holds a one-hot
//               command until the navigation FSM accepts it, and abandons
//               it after ACK_TIMEOUT ticks without acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module auto_route_cmd #(
    parameter int DEBOUNCE    = 3,
    parameter int ACK_TIMEOUT = 50,
    parameter int MAX_RIGHT   = 4
) (
    input  wire logic       clk_20ms,
    input  wire logic       rst,
    auto_route_cmd_if.slave cmd_if
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0] NAV_FORWARD = 2'b00;
    localparam logic [1:0] NAV_WAITING = 2'b01;

    // Command vector order is {left, right, straight, back}.
    localparam logic [3:0] CMD_NONE     = 4'b0000;
    localparam logic [3:0] CMD_LEFT     = 4'b1000;
    localparam logic [3:0] CMD_RIGHT    = 4'b0100;
    localparam logic [3:0] CMD_STRAIGHT = 4'b0010;
    localparam logic [3:0] CMD_BACK     = 4'b0001;

    localparam logic [3:0] STAB_LAST = 4'(DEBOUNCE - 1);
    localparam logic [5:0] ISS_LAST  = 6'(ACK_TIMEOUT - 1);
    localparam logic [2:0] RUN_LIMIT = 3'(MAX_RIGHT);
    localparam logic [2:0] RUN_SAT   = 3'd7;

    state_t     state_q,    state_d;
    logic [3:0] snap_q,     snap_d;
    logic [3:0] stab_cnt_q, stab_cnt_d;
    logic [5:0] iss_cnt_q,  iss_cnt_d;
    logic [3:0] cmd_q,      cmd_d;
    logic [2:0] run_q,      run_d;
    logic       tmo_q,      tmo_d;

    logic       front_clear;
    logic       left_open;
    logic       right_open;
    logic [3:0] decision;

    // Direction choice from the debounced snapshot: right-hand rule first,
    // a guard-skipped right only when nothing else is open.
    always_comb begin
        front_clear = ~snap_q[0];
        left_open   = ~snap_q[1];
        right_open  = ~snap_q[2];
        if (right_open && (run_q < RUN_LIMIT)) begin
            decision = CMD_RIGHT;
        end else if (front_clear) begin
            decision = CMD_STRAIGHT;
        end else if (left_open) begin
            decision = CMD_LEFT;
        end else if (right_open) begin
            decision = CMD_RIGHT;
        end else begin
            decision = CMD_BACK;
        end
    end

    // State register and all datapath registers.
    always_ff @(posedge clk_20ms) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= 4'd0;
            stab_cnt_q <= 4'd0;
            iss_cnt_q  <= 6'd0;
            cmd_q      <= CMD_NONE;
            run_q      <= 3'd0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            stab_cnt_q <= stab_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            cmd_q      <= cmd_d;
            run_q      <= run_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state logic: debounce, issue, acceptance/timeout, release.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        stab_cnt_d = stab_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        cmd_d      = cmd_q;
        run_d      = run_q;
        tmo_d      = 1'b0;

        if (!cmd_if.enable) begin
            state_d = IDLE;
            cmd_d   = CMD_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    snap_d     = cmd_if.detector;
                    stab_cnt_d = 4'd0;
                    cmd_d      = CMD_NONE;
                    if (cmd_if.nav_state == NAV_WAITING) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cmd_if.nav_state != NAV_WAITING) begin
                        state_d = IDLE;
                    end else if (cmd_if.detector != snap_q) begin
                        // Any change restarts the whole debounce window.
                        snap_d     = cmd_if.detector;
                        stab_cnt_d = 4'd0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_d   = ISSUE;
                        cmd_d     = decision;
                        iss_cnt_d = 6'd0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + 4'd1;
                    end
                end
                ISSUE: begin
                    // Acceptance wins over timeout on the same edge.
                    if (cmd_if.nav_state != NAV_WAITING) begin
                        state_d = WAIT_DONE;
                        cmd_d   = CMD_NONE;
                        if (cmd_q == CMD_RIGHT) begin
                            run_d = (run_q == RUN_SAT) ? run_q : run_q + 3'd1;
                        end else begin
                            run_d = 3'd0;
                        end
                    end else if (iss_cnt_q == ISS_LAST) begin
                        state_d = IDLE;
                        cmd_d   = CMD_NONE;
                        tmo_d   = 1'b1;
                    end else begin
                        iss_cnt_d = iss_cnt_q + 6'd1;
                    end
                end
                WAIT_DONE: begin
                    cmd_d = CMD_NONE;
                    if (cmd_if.nav_state == NAV_FORWARD) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cmd_d   = CMD_NONE;
                end
            endcase
        end
    end

    assign cmd_if.left        = cmd_q[3];
    assign cmd_if.right       = cmd_q[2];
    assign cmd_if.straight    = cmd_q[1];
    assign cmd_if.back        = cmd_q[0];
    assign cmd_if.busy        = (state_q != IDLE);
    assign cmd_if.timeout_err = tmo_q;
    assign cmd_if.right_run   = run_q;

endmodule
`default_nettype wire

// File: tb/tb_auto_route_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_auto_route_cmd
// Description : Self-checking bench for auto_route_cmd: direction table,
//               hand-written corner sequences and a randomized run against
//               a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_route_cmd;

    localparam int DEBOUNCE    = 3;
    localparam int ACK_TIMEOUT = 50;
    localparam int MAX_RIGHT   = 4;

    localparam logic [3:0] C_NONE     = 4'b0000;
    localparam logic [3:0] C_LEFT     = 4'b1000;
    localparam logic [3:0] C_RIGHT    = 4'b0100;
    localparam logic [3:0] C_STRAIGHT = 4'b0010;
    localparam logic [3:0] C_BACK     = 4'b0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    auto_route_cmd_if ifc ();

    auto_route_cmd #(
        .DEBOUNCE    (DEBOUNCE),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RIGHT   (MAX_RIGHT)
    ) dut (
        .clk_20ms (clk),
        .rst      (rst),
        .cmd_if   (ifc)
    );

    logic [3:0] cmd;
    assign cmd = {ifc.left, ifc.right, ifc.straight, ifc.back};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] det;
        logic [3:0] exp_cmd;
        logic [1:0] acc_nav;
    } vec_t;
    vec_t tab [8];

    // Reference model state: phase 0 idle, 1 gathering samples,
    // 2 command held, 3 waiting for forward motion.
    int         m_phase;
    logic [3:0] m_hist [$];
    logic [3:0] m_cmd;
    int         m_held;
    int         m_run;
    logic       m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        ifc.enable    = 1'b1;
        ifc.nav_state = 2'b00;
        ifc.detector  = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] decide(input logic [3:0] d, input int run);
        bit front_clear = !d[0];
        bit left_open   = !d[1];
        bit right_open  = !d[2];
        if (right_open && run < MAX_RIGHT) return C_RIGHT;
        if (front_clear) return C_STRAIGHT;
        if (left_open) return C_LEFT;
        if (right_open) return C_RIGHT;
        return C_BACK;
    endfunction

    // Decision is taken once the last DEBOUNCE+1 samples since the
    // waiting state was seen are all identical.
    function automatic bit tail_stable();
        int n = m_hist.size();
        if (n < DEBOUNCE + 1) return 1'b0;
        for (int i = 1; i <= DEBOUNCE; i++) begin
            if (m_hist[n-1-i] != m_hist[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic en, input logic [1:0] nav, input logic [3:0] det);
        m_to = 1'b0;
        if (!en) begin
            m_phase = 0;
            m_cmd   = C_NONE;
        end else begin
            case (m_phase)
                0: if (nav == 2'b01) begin
                    m_hist.delete();
                    m_hist.push_back(det);
                    m_phase = 1;
                end
                1: if (nav != 2'b01) begin
                    m_phase = 0;
                end else begin
                    m_hist.push_back(det);
                    if (m_hist.size() > 32) void'(m_hist.pop_front());
                    if (tail_stable()) begin
                        m_cmd   = decide(det, m_run);
                        m_held  = 0;
                        m_phase = 2;
                    end
                end
                2: if (nav != 2'b01) begin
                    m_run   = (m_cmd == C_RIGHT) ? ((m_run < 7) ? m_run + 1 : 7) : 0;
                    m_cmd   = C_NONE;
                    m_phase = 3;
                end else begin
                    m_held++;
                    if (m_held == ACK_TIMEOUT) begin
                        m_cmd   = C_NONE;
                        m_to    = 1'b1;
                        m_phase = 0;
                    end
                end
                default: if (nav == 2'b00) m_phase = 0;
            endcase
        end
    endtask

    // Waiting -> debounced command -> acceptance -> forward, from idle.
    task automatic issue_and_accept(input logic [3:0] det, input logic [3:0] exp_cmd,
                                    input logic [1:0] acc, input logic [2:0] exp_run);
        ifc.detector  = det;
        ifc.nav_state = 2'b01;
        repeat (DEBOUNCE) tick();
        check("no_early_cmd", cmd, C_NONE);
        tick();
        check("cmd", cmd, exp_cmd);
        ifc.nav_state = acc;
        tick();
        check("drop_on_accept", cmd, C_NONE);
        check("right_run", ifc.right_run, exp_run);
        check("busy_wait_done", ifc.busy, 1'b1);
        ifc.nav_state = 2'b00;
        tick();
        check("idle_after_fwd", ifc.busy, 1'b0);
    endtask

    task automatic hold_until_issue(input logic [3:0] det);
        ifc.detector  = det;
        ifc.nav_state = 2'b01;
        repeat (DEBOUNCE + 1) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       en_r;
        logic [1:0] nav_r;
        logic [3:0] det_r;
        int         seg;

        tab[0] = '{4'b0000, C_RIGHT,    2'b10};
        tab[1] = '{4'b0100, C_STRAIGHT, 2'b11};
        tab[2] = '{4'b0101, C_LEFT,     2'b10};
        tab[3] = '{4'b0111, C_BACK,     2'b10};
        tab[4] = '{4'b0110, C_STRAIGHT, 2'b11};
        tab[5] = '{4'b1011, C_RIGHT,    2'b10};
        tab[6] = '{4'b0011, C_RIGHT,    2'b11};
        tab[7] = '{4'b1111, C_BACK,     2'b10};

        do_reset();
        check("reset_state",
              {cmd, ifc.busy, ifc.timeout_err, ifc.right_run}, 9'd0);

        // Direction table, each from a fresh reset (right_run = 0).
        for (int i = 0; i < 8; i++) begin
            do_reset();
            issue_and_accept(tab[i].det, tab[i].exp_cmd, tab[i].acc_nav,
                             (tab[i].exp_cmd == C_RIGHT) ? 3'd1 : 3'd0);
        end

        // Loop guard: four rights, then right is skipped for left/straight.
        do_reset();
        for (int r = 0; r < 4; r++) issue_and_accept(4'b0000, C_RIGHT, 2'b10, 3'(r + 1));
        issue_and_accept(4'b0001, C_LEFT, 2'b10, 3'd0);
        for (int r = 0; r < 4; r++) issue_and_accept(4'b0000, C_RIGHT, 2'b10, 3'(r + 1));
        issue_and_accept(4'b0011, C_RIGHT, 2'b10, 3'd5);
        issue_and_accept(4'b0000, C_STRAIGHT, 2'b10, 3'd0);

        // Acknowledge timeout, then re-entry into debounce.
        do_reset();
        hold_until_issue(4'b0111);
        check("tmo_cmd_up", cmd, C_BACK);
        repeat (ACK_TIMEOUT - 1) tick();
        check("tmo_still_held", {cmd, ifc.timeout_err}, {C_BACK, 1'b0});
        tick();
        check("tmo_drop", {cmd, ifc.timeout_err, ifc.busy}, {C_NONE, 1'b1, 1'b0});
        check("tmo_run_kept", ifc.right_run, 3'd0);
        tick();
        check("tmo_single_pulse", ifc.timeout_err, 1'b0);
        check("tmo_resettle", ifc.busy, 1'b1);

        // Detector toggling restarts the window each time.
        do_reset();
        ifc.nav_state = 2'b01;
        for (int i = 0; i < 10; i++) begin
            ifc.detector = (i % 2 == 1) ? 4'b0111 : 4'b0000;
            tick();
            check("toggle_no_cmd", cmd, C_NONE);
        end
        ifc.detector = 4'b0101;
        for (int i = 0; i < DEBOUNCE; i++) begin
            tick();
            check("stable_no_cmd", cmd, C_NONE);
        end
        tick();
        check("stable_cmd", cmd, C_LEFT);

        // Reset while a command is held.
        do_reset();
        issue_and_accept(4'b0000, C_RIGHT, 2'b10, 3'd1);
        hold_until_issue(4'b0000);
        check("pre_rst_cmd", cmd, C_RIGHT);
        rst = 1'b1;
        tick();
        check("rst_mid_issue",
              {cmd, ifc.busy, ifc.timeout_err, ifc.right_run}, 9'd0);
        rst = 1'b0;

        // Enable dropped while a command is held: right_run kept.
        do_reset();
        issue_and_accept(4'b0000, C_RIGHT, 2'b10, 3'd1);
        hold_until_issue(4'b0000);
        ifc.enable = 1'b0;
        tick();
        check("en_low_mid_issue",
              {cmd, ifc.busy, ifc.timeout_err, ifc.right_run},
              {C_NONE, 1'b0, 1'b0, 3'd1});
        ifc.enable = 1'b1;

        // Randomized run against the behavioural model.
        do_reset();
        m_phase = 0; m_cmd = C_NONE; m_held = 0; m_run = 0; m_to = 1'b0;
        m_hist.delete();
        en_r = 1'b1; nav_r = 2'b00; det_r = 4'b0000; seg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                nav_r = 2'($urandom_range(0, 3));
                seg   = $urandom_range(1, 70);
            end
            seg--;
            if ($urandom_range(0, 4) == 0)
                det_r = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
            en_r = ($urandom_range(0, 99) != 0);
            ifc.enable    = en_r;
            ifc.nav_state = nav_r;
            ifc.detector  = det_r;
            tick();
            model_step(en_r, nav_r, det_r);
            check("random",
                  {cmd, ifc.busy, ifc.timeout_err, ifc.right_run},
                  {m_cmd, (m_phase != 0), m_to, 3'(m_run)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
